// File: rtl/counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl
//   Command-driven sequencer around a WIDTH-bit up-counter. A host starts,
//   pauses, resumes or aborts the count through a valid/ready command port.
//   The block flags terminal count with a one-cycle done pulse and flags
//   commands that are illegal in the current state with a one-cycle err pulse.
//
// Parameters
//   WIDTH     count/limit width in bits
//   PRESCALE  clk cycles per increment (>=1)
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   cmd_valid   in   command present
//   cmd_ready   out  command can be accepted (low only in DONE)
//   cmd_op      in   0=START 1=PAUSE 2=RESUME 3=ABORT
//   cmd_limit   in   terminal value, sampled on accepted START
//   cmd_reload  in   auto-reload mode, sampled on accepted START
//   value       out  current count (registered)
//   busy        out  high in RUN or PAUSE
//   done        out  one-cycle terminal-count pulse
//   err         out  one-cycle illegal-command pulse
//   irq         out  sticky terminal-count flag  (COUNTER_SEQ_IRQ_EN only)
//   irq_clr     in   clears irq                  (COUNTER_SEQ_IRQ_EN only)
//
// Configuration
//   COUNTER_SEQ_IRQ_EN : when defined, adds the irq/irq_clr ports.
// ---------------------------------------------------------------------------
module counter_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_reload,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef COUNTER_SEQ_IRQ_EN
  ,
  output logic             irq,
  input  logic             irq_clr
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_START  = 2'd0;
  localparam logic [1:0] OP_PAUSE  = 2'd1;
  localparam logic [1:0] OP_RESUME = 2'd2;
  localparam logic [1:0] OP_ABORT  = 2'd3;

  // Prescaler needs at least one bit even when PRESCALE=1.
  localparam int              PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PMAX = PW'(PRESCALE - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_value;
  logic [PW-1:0]    r_presc;
  logic [WIDTH-1:0] r_limit;
  logic             r_reload;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_value_nxt;
  logic [PW-1:0]    w_presc_nxt;
  logic             w_latch;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic             w_hold;
  logic             w_accept;
  logic             w_strobe;

  assign w_accept = cmd_valid && (r_state != S_DONE);
  assign w_strobe = (r_state == S_RUN) && (r_presc == PMAX);

  always_comb begin
    w_state_nxt = r_state;
    w_value_nxt = r_value;
    w_presc_nxt = r_presc;
    w_latch     = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_hold      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_START: begin
              w_state_nxt = S_RUN;
              w_value_nxt = '0;
              w_presc_nxt = '0;
              w_latch     = 1'b1;
            end
            OP_ABORT: w_value_nxt = '0;
            default:  w_err_nxt   = 1'b1;
          endcase
        end
      end

      S_RUN: begin
        // The prescaler runs on every RUN cycle; an accepted PAUSE/ABORT
        // only blocks the value/done effect of a coinciding strobe.
        w_presc_nxt = w_strobe ? '0 : r_presc + PW'(1);
        if (w_accept) begin
          case (cmd_op)
            OP_PAUSE: begin
              w_state_nxt = S_PAUSE;
              w_hold      = 1'b1;
            end
            OP_ABORT: begin
              w_state_nxt = S_IDLE;
              w_value_nxt = '0;
              w_presc_nxt = '0;
              w_hold      = 1'b1;
            end
            default: w_err_nxt = 1'b1;
          endcase
        end
        if (w_strobe && !w_hold) begin
          if (r_value == r_limit) begin
            w_done_nxt = 1'b1;
            if (r_reload) w_value_nxt = '0;
            else          w_state_nxt = S_DONE;
          end else begin
            w_value_nxt = r_value + WIDTH'(1);
          end
        end
      end

      S_PAUSE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_RESUME: w_state_nxt = S_RUN;
            OP_ABORT: begin
              w_state_nxt = S_IDLE;
              w_value_nxt = '0;
              w_presc_nxt = '0;
            end
            default: w_err_nxt = 1'b1;
          endcase
        end
      end

      S_DONE: w_state_nxt = S_IDLE;

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_value  <= '0;
      r_presc  <= '0;
      r_limit  <= '0;
      r_reload <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_value <= w_value_nxt;
      r_presc <= w_presc_nxt;
      if (w_latch) begin
        r_limit  <= cmd_limit;
        r_reload <= cmd_reload;
      end
      r_busy <= (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE);
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign cmd_ready = (r_state != S_DONE);
  assign value     = r_value;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

`ifdef COUNTER_SEQ_IRQ_EN
  logic r_irq;

  // A new terminal count takes priority over a clear on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_irq <= 1'b0;
    else if (w_done_nxt) r_irq <= 1'b1;
    else if (irq_clr)    r_irq <= 1'b0;
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
module tb_counter_seq_ctrl;

  localparam logic [1:0] OP_START  = 2'd0;
  localparam logic [1:0] OP_PAUSE  = 2'd1;
  localparam logic [1:0] OP_RESUME = 2'd2;
  localparam logic [1:0] OP_ABORT  = 2'd3;

  logic       clk;
  logic       reset;

  // PRESCALE=1 instance
  logic       c_valid;
  logic [1:0] c_op;
  logic [7:0] c_lim;
  logic       c_rld;
  logic       c_ready;
  logic [7:0] c_value;
  logic       c_busy;
  logic       c_done;
  logic       c_err;

  // PRESCALE=4 instance
  logic       q_valid;
  logic [1:0] q_op;
  logic [7:0] q_lim;
  logic       q_rld;
  logic       q_ready;
  logic [7:0] q_value;
  logic       q_busy;
  logic       q_done;
  logic       q_err;

`ifdef COUNTER_SEQ_IRQ_EN
  logic c_irq, c_irq_clr, q_irq, q_irq_clr;
`endif

  int n_vec = 0;
  int n_err = 0;

  counter_seq_ctrl #(.WIDTH(8), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(c_valid), .cmd_ready(c_ready), .cmd_op(c_op),
    .cmd_limit(c_lim), .cmd_reload(c_rld),
    .value(c_value), .busy(c_busy), .done(c_done), .err(c_err)
`ifdef COUNTER_SEQ_IRQ_EN
    , .irq(c_irq), .irq_clr(c_irq_clr)
`endif
  );

  counter_seq_ctrl #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset),
    .cmd_valid(q_valid), .cmd_ready(q_ready), .cmd_op(q_op),
    .cmd_limit(q_lim), .cmd_reload(q_rld),
    .value(q_value), .busy(q_busy), .done(q_done), .err(q_err)
`ifdef COUNTER_SEQ_IRQ_EN
    , .irq(q_irq), .irq_clr(q_irq_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs and samples sit 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] lim, input logic rld);
    c_valid = 1'b1; c_op = op; c_lim = lim; c_rld = rld;
    step();
    c_valid = 1'b0;
  endtask

  task automatic issue4(input logic [1:0] op, input logic [7:0] lim, input logic rld);
    q_valid = 1'b1; q_op = op; q_lim = lim; q_rld = rld;
    step();
    q_valid = 1'b0;
  endtask

  initial begin
    c_valid = 0; c_op = 0; c_lim = 0; c_rld = 0;
    q_valid = 0; q_op = 0; q_lim = 0; q_rld = 0;
`ifdef COUNTER_SEQ_IRQ_EN
    c_irq_clr = 0; q_irq_clr = 0;
`endif
    reset = 1'b0;
    #1 reset = 1'b1;

    // Reset held 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_value", c_value, 0);
      chk("rst_busy",  c_busy,  0);
      chk("rst_done",  c_done,  0);
      chk("rst_err",   c_err,   0);
      chk("rst_ready", c_ready, 1);
    end
    reset = 1'b0;
    step();

    // One-shot count to 5
    issue(OP_START, 8'd5, 1'b0);
    chk("os_v0",    c_value, 0);
    chk("os_busy0", c_busy,  1);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("os_value", c_value, k);
      chk("os_done",  c_done,  0);
    end
    step();
    chk("os_done6",  c_done,  1);
    chk("os_ready6", c_ready, 0);
    chk("os_value6", c_value, 5);
    chk("os_busy6",  c_busy,  0);
    step();
    chk("os_done7",  c_done,  0);
    chk("os_ready7", c_ready, 1);
    chk("os_value7", c_value, 5);
    chk("os_busy7",  c_busy,  0);

    // Auto-reload with limit 3
    issue(OP_START, 8'd3, 1'b1);
    chk("rl_v0", c_value, 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("rl_value", c_value, k % 4);
      chk("rl_done",  c_done,  (k % 4 == 0) ? 1 : 0);
      chk("rl_busy",  c_busy,  1);
    end
    issue(OP_ABORT, 8'd0, 1'b0);
    chk("rl_abort_v", c_value, 0);
    chk("rl_abort_b", c_busy,  0);

    // Pause / resume, PRESCALE=1
    issue(OP_START, 8'd20, 1'b0);
    step();
    step();
    chk("pa_pre", c_value, 2);
    issue(OP_PAUSE, 8'd0, 1'b0);
    chk("pa_v", c_value, 2);
    chk("pa_b", c_busy,  1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("pa_hold", c_value, 2);
    end
    issue(OP_RESUME, 8'd0, 1'b0);
    chk("re_v", c_value, 2);
    chk("re_b", c_busy,  1);
    step();
    chk("re_v1", c_value, 3);
    issue(OP_ABORT, 8'd0, 1'b0);
    chk("pa_abort", c_value, 0);

    // Illegal START while running; ABORT on the limit strobe
    issue(OP_START, 8'd5, 1'b0);
    step();
    step();
    issue(OP_START, 8'd9, 1'b0);
    chk("il_err",  c_err,   1);
    chk("il_v3",   c_value, 3);
    step();
    chk("il_err0", c_err,   0);
    chk("il_v4",   c_value, 4);
    step();
    chk("il_v5",   c_value, 5);
    issue(OP_ABORT, 8'd0, 1'b0);
    chk("ab_v",    c_value, 0);
    chk("ab_busy", c_busy,  0);
    chk("ab_done", c_done,  0);
    step();
    chk("ab_done1", c_done, 0);

    // Illegal RESUME in IDLE
    issue(OP_RESUME, 8'd0, 1'b0);
    chk("id_err",  c_err,  1);
    chk("id_busy", c_busy, 0);
    step();
    chk("id_err0", c_err,  0);

    // Pause / resume, PRESCALE=4: prescaler phase preserved
    issue4(OP_START, 8'd10, 1'b0);
    for (int i = 1; i <= 10; i++) step();
    chk("p4_v2", q_value, 2);
    issue4(OP_PAUSE, 8'd0, 1'b0);
    chk("p4_pause", q_value, 2);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("p4_hold", q_value, 2);
    end
    issue4(OP_RESUME, 8'd0, 1'b0);
    chk("p4_res", q_value, 2);
    step();
    chk("p4_v3", q_value, 3);
    for (int i = 0; i < 3; i++) step();
    chk("p4_v3b", q_value, 3);
    step();
    chk("p4_v4", q_value, 4);
    issue4(OP_ABORT, 8'd0, 1'b0);

`ifdef COUNTER_SEQ_IRQ_EN
    // irq: done with simultaneous clear keeps irq set
    issue(OP_START, 8'd0, 1'b1);
    step();
    chk("irq_set", c_irq, 1);
    c_irq_clr = 1'b1;
    step();
    chk("irq_win", c_irq, 1);
    issue(OP_ABORT, 8'd0, 1'b0);
    chk("irq_clr", c_irq, 0);
    c_irq_clr = 1'b0;
    issue(OP_START, 8'd0, 1'b1);
    step();
    chk("irq_set2", c_irq, 1);
    #2 reset = 1'b1;
    #1;
    chk("irq_rst", c_irq, 0);
    step();
    reset = 1'b0;
    step();
`endif

    // Asynchronous reset mid-run at value 4
    issue(OP_START, 8'd9, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("ar_pre", c_value, 4);
    #2 reset = 1'b1;
    #1;
    chk("ar_value", c_value, 0);
    chk("ar_busy",  c_busy,  0);
    chk("ar_ready", c_ready, 1);
    step();
    reset = 1'b0;
    chk("ar_done", c_done, 0);
    chk("ar_err",  c_err,  0);
    step();
    chk("ar_value2", c_value, 0);
    chk("ar_busy2",  c_busy,  0);
    chk("ar_done2",  c_done,  0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
